// File: rtl/axis_arb_pkg.sv
// Shared definitions for the AXI4-Stream FIFO round-robin arbiter.
//   arb_state_e : one-hot controller state encoding (IDLE / READ / SEND)
//   clog2_safe  : index width helper that never returns 0 (1 for n <= 1)
package axis_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_READ = 3'b010,
    ST_SEND = 3'b100
  } arb_state_e;

  function automatic int clog2_safe(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_fifo_rr_arbiter_rr_select.sv
// Combinational round-robin picker.
//   req   : per-source request bits
//   ptr   : highest-priority source for this pick
//   found : at least one request is set
//   idx   : first requesting source at or above ptr, wrapping to 0
module rr_select #(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_SRC);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/axis_fifo_rr_arbiter.sv
// Shares one AXI4-Stream master between NUM_SRC ingress FIFOs (1-cycle read
// latency, dout holds after a read). A non-empty FIFO is picked round-robin
// and up to MAX_BURST beats are streamed from it before re-arbitrating.
//
// Ports:
//   M_AXIS_ACLK / M_AXIS_ARESETN : clock, async active-low reset
//   M_AXIS_TVALID/TDATA/TREADY   : AXIS master output
//   fifo_dout   : concatenated FIFO read data, source i at [i*W +: W]
//   fifo_empty  : per-FIFO empty flags
//   fifo_rd_en  : per-FIFO read enable, one-hot or zero
//   grant_idx   : currently granted source
//   busy        : controller not in IDLE
//   M_AXIS_TID  : granted source index (only when ARB_TID_EN is defined)
//
// State | meaning
// IDLE  | wait for any non-empty FIFO, latch round-robin pick into grant
// READ  | one-cycle read of the granted FIFO; its word lands next cycle
// SEND  | present word; on handshake read ahead or end burst
module axis_fifo_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int NUM_SRC              = 4,
  parameter int MAX_BURST            = 8,
  localparam int IDX_W               = clog2_safe(NUM_SRC)
) (
  input  logic                              M_AXIS_ACLK,
  input  logic                              M_AXIS_ARESETN,
  output logic                              M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  input  logic                              M_AXIS_TREADY,
  input  logic [NUM_SRC*C_M_AXIS_TDATA_WIDTH-1:0] fifo_dout,
  input  logic [NUM_SRC-1:0]                fifo_empty,
  output logic [NUM_SRC-1:0]                fifo_rd_en,
  output logic [IDX_W-1:0]                  grant_idx,
  output logic                              busy
`ifdef ARB_TID_EN
  ,output logic [IDX_W-1:0]                 M_AXIS_TID
`endif
);

  localparam int W     = C_M_AXIS_TDATA_WIDTH;
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] LAST_SRC  = IDX_W'(NUM_SRC - 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [NUM_SRC-1:0] req;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               handshake;
  logic               burst_more;
  logic               sel_empty;
  logic [W-1:0]       sel_data;

  assign req = ~fifo_empty;

  rr_select #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .req   (req),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Granted-source view of the FIFO side, decoded with constant indices.
  always_comb begin
    sel_empty = 1'b1;
    sel_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q == IDX_W'(i)) begin
        sel_empty = fifo_empty[i];
        sel_data  = fifo_dout[i*W +: W];
      end
    end
  end

  assign handshake  = (state_q == ST_SEND) && M_AXIS_TREADY;
  // Read ahead only while the burst has room and the granted FIFO has data.
  assign burst_more = (beat_cnt_q < LAST_BEAT) && !sel_empty;

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = ST_READ;
        end
      end
      ST_READ: state_d = ST_SEND;
      ST_SEND: begin
        if (handshake) begin
          if (burst_more) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end else begin
            state_d  = ST_IDLE;
            rr_ptr_d = (grant_q == LAST_SRC) ? '0 : grant_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    M_AXIS_TVALID = (state_q == ST_SEND);
    busy          = (state_q != ST_IDLE);
    fifo_rd_en    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if ((grant_q == IDX_W'(i)) &&
          ((state_q == ST_READ) || (handshake && burst_more))) begin
        fifo_rd_en[i] = 1'b1;
      end
    end
  end

  assign M_AXIS_TDATA = sel_data;
  assign grant_idx    = grant_q;

`ifdef ARB_TID_EN
  assign M_AXIS_TID = grant_q;
`endif

endmodule

// File: tb/tb_axis_fifo_rr_arbiter.sv
module tb_axis_fifo_rr_arbiter;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int MB = 8;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            tvalid;
  logic            tready;
  logic [W-1:0]    tdata;
  logic [N*W-1:0]  fifo_dout;
  logic [N-1:0]    fifo_empty;
  logic [N-1:0]    rd_en;
  logic [IW-1:0]   grant_idx;
  logic            busy;
`ifdef ARB_TID_EN
  logic [IW-1:0]   m_axis_tid;
`endif

  always #5 clk = ~clk;

  axis_fifo_rr_arbiter #(
    .C_M_AXIS_TDATA_WIDTH (W),
    .NUM_SRC              (N),
    .MAX_BURST            (MB)
  ) dut (
    .M_AXIS_ACLK    (clk),
    .M_AXIS_ARESETN (rst_n),
    .M_AXIS_TVALID  (tvalid),
    .M_AXIS_TDATA   (tdata),
    .M_AXIS_TREADY  (tready),
    .fifo_dout      (fifo_dout),
    .fifo_empty     (fifo_empty),
    .fifo_rd_en     (rd_en),
    .grant_idx      (grant_idx),
    .busy           (busy)
`ifdef ARB_TID_EN
    ,.M_AXIS_TID    (m_axis_tid)
`endif
  );

  typedef struct {
    int           src;
    logic [W-1:0] data;
    bit           last;
  } beat_t;

  logic [W-1:0] fq[N][$];
  beat_t        exp_q[$];
  int           model_ptr = 0;
  int           checks = 0;
  int           errors = 0;
  int           gap_pos = 0;
  bit           prev_stall = 0;
  logic [W-1:0] prev_data = '0;
  int           rd_cnt = 0;
  int           beats_done = 0;
  int           cyc = 0;
  int           tready_mode = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void update_flags();
    for (int i = 0; i < N; i++) fifo_empty[i] = (fq[i].size() == 0);
  endfunction

  // Transaction-level expectation: bursts of min(MB, words queued) from the
  // first non-empty source at or after the priority pointer.
  function automatic void build_model();
    int    taken[N];
    int    s;
    int    n;
    int    c;
    bit    any;
    beat_t b;
    for (int i = 0; i < N; i++) taken[i] = 0;
    while (1) begin
      any = 0;
      s   = 0;
      for (int k = 0; k < N; k++) begin
        c = (model_ptr + k) % N;
        if (!any && (fq[c].size() > taken[c])) begin
          any = 1;
          s   = c;
        end
      end
      if (!any) break;
      n = fq[s].size() - taken[s];
      if (n > MB) n = MB;
      for (int j = 0; j < n; j++) begin
        b.src  = s;
        b.data = fq[s][taken[s] + j];
        b.last = (j == n - 1);
        exp_q.push_back(b);
      end
      taken[s] += n;
      model_ptr = (s + 1) % N;
    end
  endfunction

  task automatic fill(input int s, input int n);
    for (int j = 0; j < n; j++) fq[s].push_back($urandom);
  endtask

  // One cycle: observe at negedge, then apply FIFO reads and new TREADY
  // just after the posedge.
  task automatic step();
    logic [N-1:0] rd_s;
    logic         hs;
    beat_t        e;
    @(negedge clk);
    rd_s = rd_en;
    hs   = tvalid & tready;
    check_eq("rd_en_legal", (((rd_s & fifo_empty) != '0) || !$onehot0(rd_s)), 0);
    if (tvalid && !tready) check_eq("rd_en_stall", rd_s, 0);
    if (prev_stall) begin
      check_eq("hold_valid", tvalid, 1);
      check_eq("hold_data", tdata, prev_data);
    end
    if (gap_pos > 0) begin
      if (gap_pos < 3) check_eq("gap_valid", tvalid, 0);
      else             check_eq("regrant_valid", tvalid, (exp_q.size() > 0));
      gap_pos = (gap_pos == 3) ? 0 : gap_pos + 1;
    end
    if (hs) begin
      beats_done++;
      check_eq("beat_expected", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("tdata", tdata, e.data);
        check_eq("grant", grant_idx, e.src);
`ifdef ARB_TID_EN
        check_eq("tid", m_axis_tid, e.src);
`endif
        if (e.last) gap_pos = 1;
      end
    end
    rd_cnt    += $countones(rd_s);
    prev_stall = tvalid && !tready;
    prev_data  = tdata;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (rd_s[i] && (fq[i].size() > 0)) fifo_dout[i*W +: W] = fq[i].pop_front();
    update_flags();
    cyc++;
    case (tready_mode)
      0:       tready = 1'b1;
      1:       tready = ($urandom_range(0, 3) != 0);
      default: tready = !((cyc >= 8) && (cyc < 13));
    endcase
  endtask

  task automatic run_phase(input int mode, input int rst_after);
    int total;
    bit did_rst;
    total   = 0;
    did_rst = 0;
    for (int i = 0; i < N; i++) total += fq[i].size();
    rd_cnt      = 0;
    beats_done  = 0;
    cyc         = 0;
    tready_mode = mode;
    tready      = (mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b1;
    update_flags();
    exp_q.delete();
    build_model();
    gap_pos    = 1;
    prev_stall = 0;
    while (((exp_q.size() > 0) || (gap_pos != 0)) && (cyc < 3000)) begin
      step();
      if ((rst_after >= 0) && !did_rst && (beats_done >= rst_after)) begin
        did_rst = 1;
        #1;
        check_eq("pre_rst_valid", tvalid, 1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_tvalid", tvalid, 0);
        check_eq("rst_rd_en", rd_en, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_grant", grant_idx, 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        exp_q.delete();
        model_ptr = 0;
        build_model();
        gap_pos    = 1;
        prev_stall = 0;
      end
    end
    check_eq("phase_done", ((exp_q.size() == 0) && (gap_pos == 0)), 1);
    check_eq("busy_idle", busy, 0);
    check_eq("rd_count", rd_cnt, total);
    check_eq("fifos_drained", fifo_empty, 4'hF);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int tot;
    tready     = 1'b1;
    fifo_dout  = '0;
    fifo_empty = '1;
    rst_n      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_tvalid", tvalid, 0);
    check_eq("reset_rd_en", rd_en, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_grant", grant_idx, 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single source, three words
    fill(0, 3);
    run_phase(0, -1);
    // one word from source 1 moves priority to source 2
    fill(1, 1);
    run_phase(0, -1);
    // early empty on source 2; source 3 served before source 0
    fill(0, 5); fill(2, 2); fill(3, 3);
    run_phase(0, -1);
    // fairness with full bursts
    for (int s = 0; s < N; s++) fill(s, 20);
    run_phase(0, -1);
    // TREADY low for five cycles mid-burst
    for (int s = 0; s < N; s++) fill(s, 6);
    run_phase(2, -1);
    // randomized traffic and backpressure
    for (int p = 0; p < 6; p++) begin
      tot = 0;
      for (int s = 0; s < N; s++) begin
        cnt = $urandom_range(0, 20);
        fill(s, cnt);
        tot += cnt;
      end
      if (tot == 0) fill($urandom_range(0, N - 1), 1);
      run_phase(1, -1);
    end
    // asynchronous reset in the middle of the second burst
    for (int s = 0; s < N; s++) fill(s, 12);
    run_phase(1, 10);
    // traffic after reset
    for (int s = 0; s < N; s++) fill(s, $urandom_range(1, 12));
    run_phase(1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
